// File: rtl/comparador_serial_izq_der_pkg.sv
// Shared encodings for the MSB-first serial word comparator.
// Holds the relation codes (P), the FSM state codes and the relation-to-flag decode.
package comparador_serial_izq_der_pkg;

  // Running relation between the bits of A and B seen so far.
  typedef enum logic [1:0] {
    IGUAL   = 2'b00,
    A_MAYOR = 2'b01,
    B_MAYOR = 2'b10
  } rel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPARE = 2'b01,
    DONE    = 2'b10
  } estado_t;

  // Converts a relation into one-hot result flags {a_mayor, b_mayor, iguales}.
  function automatic logic [2:0] rel_flags(input rel_t p);
    logic [2:0] f;
    case (p)
      A_MAYOR: f = 3'b100;
      B_MAYOR: f = 3'b010;
      IGUAL:   f = 3'b001;
      default: f = 3'b000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/comparador_serial_izq_der_if.sv
// Handshake and result bundle between a serial bit source and the comparator.
// The master modport belongs to the source/controller, the slave modport to the comparator.
interface comparador_serial_izq_der_if #(
  parameter int N = 8
);
  localparam int CW = $clog2(N + 1);

  logic          start;
  logic          bit_valid;
  logic          a_bit;
  logic          b_bit;
  logic          bit_ready;
  logic          busy;
  logic          done;
  logic          a_mayor;
  logic          b_mayor;
  logic          iguales;
  logic          result_valid;
  logic [CW-1:0] bit_count;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  bit_ready, busy, done, a_mayor, b_mayor, iguales, result_valid, bit_count
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output bit_ready, busy, done, a_mayor, b_mayor, iguales, result_valid, bit_count
  );

endinterface

// File: rtl/comparador_serial_izq_der_celda.sv
// celda_izq_der: combinational left-to-right comparison cell (P, a_bit, b_bit -> P_next).
// Usable alone in the serial comparator or chained into a parallel MSB-first network.
module celda_izq_der
  import comparador_serial_izq_der_pkg::*;
(
  input  rel_t p,
  input  logic a_bit,
  input  logic b_bit,
  output rel_t p_next
);

  // Once a higher-order bit has decided the relation, lower bits cannot change it.
  always_comb begin
    p_next = IGUAL;
    case (p)
      IGUAL: begin
        if (a_bit && !b_bit) begin
          p_next = A_MAYOR;
        end else if (!a_bit && b_bit) begin
          p_next = B_MAYOR;
        end else begin
          p_next = IGUAL;
        end
      end
      A_MAYOR: p_next = A_MAYOR;
      B_MAYOR: p_next = B_MAYOR;
      default: p_next = IGUAL;
    endcase
  end

endmodule

// File: rtl/comparador_serial_izq_der.sv
// MSB-first serial A/B comparator with start/valid/ready/done handshake.
// Optional macro COMPARADOR_EARLY_DONE_EN: finish as soon as the relation is decided.
module comparador_serial_izq_der
  import comparador_serial_izq_der_pkg::*;
#(
  parameter int N = 8
) (
  input logic                        clk,
  input logic                        reset,
  comparador_serial_izq_der_if.slave bus
);

  localparam int            CW   = $clog2(N + 1);
  localparam logic [CW-1:0] N_CW = CW'(N);

  estado_t       state_r;
  estado_t       state_next_s;
  rel_t          p_r;
  rel_t          p_next_s;
  rel_t          celda_p_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic [CW-1:0] count_inc_s;
  logic [2:0]    flags_r;
  logic [2:0]    flags_next_s;
  logic          valid_r;
  logic          valid_next_s;
  logic          done_r;
  logic          done_next_s;
  logic          busy_r;
  logic          finish_s;

  celda_izq_der u_celda (
    .p      (p_r),
    .a_bit  (bus.a_bit),
    .b_bit  (bus.b_bit),
    .p_next (celda_p_s)
  );

  assign count_inc_s = (count_r == N_CW) ? count_r : count_r + {{(CW-1){1'b0}}, 1'b1};

  // Decides whether the current transfer ends the comparison.
  always_comb begin
    finish_s = 1'b0;
    if (state_r == COMPARE && bus.bit_valid) begin
      if (count_inc_s == N_CW) begin
        finish_s = 1'b1;
`ifdef COMPARADOR_EARLY_DONE_EN
      end else if (celda_p_s != IGUAL) begin
        finish_s = 1'b1;
`endif
      end else begin
        finish_s = 1'b0;
      end
    end else begin
      finish_s = 1'b0;
    end
  end

  // Next-state and next-output logic of the comparison FSM.
  always_comb begin
    state_next_s = state_r;
    p_next_s     = p_r;
    count_next_s = count_r;
    flags_next_s = flags_r;
    valid_next_s = valid_r;
    done_next_s  = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next_s = COMPARE;
          p_next_s     = IGUAL;
          count_next_s = {CW{1'b0}};
          flags_next_s = 3'b000;
          valid_next_s = 1'b0;
        end else begin
          state_next_s = state_r;
        end
      end
      COMPARE: begin
        if (bus.bit_valid) begin
          p_next_s     = celda_p_s;
          count_next_s = count_inc_s;
          if (finish_s) begin
            state_next_s = DONE;
            flags_next_s = rel_flags(celda_p_s);
            valid_next_s = 1'b1;
            done_next_s  = 1'b1;
          end else begin
            state_next_s = COMPARE;
          end
        end else begin
          state_next_s = COMPARE;
        end
      end
      default: begin
        state_next_s = IDLE;
        p_next_s     = IGUAL;
        count_next_s = {CW{1'b0}};
        flags_next_s = 3'b000;
        valid_next_s = 1'b0;
      end
    endcase
  end

  // State, relation, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      p_r     <= IGUAL;
      count_r <= {CW{1'b0}};
      flags_r <= 3'b000;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      p_r     <= p_next_s;
      count_r <= count_next_s;
      flags_r <= flags_next_s;
      valid_r <= valid_next_s;
      done_r  <= done_next_s;
      busy_r  <= (state_next_s == COMPARE);
    end
  end

  assign bus.bit_ready    = busy_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.a_mayor      = flags_r[2];
  assign bus.b_mayor      = flags_r[1];
  assign bus.iguales      = flags_r[0];
  assign bus.result_valid = valid_r;
  assign bus.bit_count    = count_r;

endmodule

// File: tb/tb_comparador_serial_izq_der.sv
// Self-checking bench for comparador_serial_izq_der (N=4): directed plan cases plus
// randomized words checked against a word-level reference model.
module tb_comparador_serial_izq_der;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  comparador_serial_izq_der_if #(.N(N)) bus ();

  comparador_serial_izq_der #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // {busy, bit_ready, done, result_valid, a_mayor, b_mayor, iguales}
  function automatic logic [6:0] status();
    return {bus.busy, bus.bit_ready, bus.done, bus.result_valid,
            bus.a_mayor, bus.b_mayor, bus.iguales};
  endfunction

  function automatic logic [2:0] ref_flags(input logic [N-1:0] a, input logic [N-1:0] b);
    if (a > b) return 3'b100;
    else if (a < b) return 3'b010;
    else return 3'b001;
  endfunction

  function automatic int ref_consumed(input logic [N-1:0] a, input logic [N-1:0] b);
    int used;
    used = N;
`ifdef COMPARADOR_EARLY_DONE_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (a[i] != b[i] && used == N) used = N - i;
    end
`endif
    return used;
  endfunction

  task automatic do_compare(input logic [N-1:0] a, input logic [N-1:0] b,
                            input int gap, input bit poke, input string name);
    logic [2:0] ef;
    int         used;
    ef   = ref_flags(a, b);
    used = ref_consumed(a, b);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (status() !== 7'b1100000 || bus.bit_count !== CW'(0)) begin
      failures++;
      $display("FAIL %s_start status=%b count=%0d expected status=1100000 count=0",
               name, status(), bus.bit_count);
    end
    for (int k = 0; k < used; k++) begin
      for (int g = 0; g < gap; g++) begin
        bus.bit_valid = 1'b0;
        bus.a_bit     = 1'($urandom);
        bus.b_bit     = 1'($urandom);
        @(negedge clk);
        checks++;
        if (status() !== 7'b1100000 || bus.bit_count !== CW'(k)) begin
          failures++;
          $display("FAIL %s_stall status=%b count=%0d expected status=1100000 count=%0d",
                   name, status(), bus.bit_count, k);
        end
      end
      bus.bit_valid = 1'b1;
      bus.a_bit     = a[N-1-k];
      bus.b_bit     = b[N-1-k];
      bus.start     = poke && (k == 1);
      @(negedge clk);
      bus.bit_valid = 1'b0;
      bus.start     = 1'b0;
      if (k < used - 1) begin
        checks++;
        if (status() !== 7'b1100000 || bus.bit_count !== CW'(k + 1)) begin
          failures++;
          $display("FAIL %s_bit%0d status=%b count=%0d expected status=1100000 count=%0d",
                   name, k, status(), bus.bit_count, k + 1);
        end
      end
    end
    checks++;
    if (status() !== {4'b0011, ef} || bus.bit_count !== CW'(used)) begin
      failures++;
      $display("FAIL %s_done status=%b count=%0d expected status=%b count=%0d",
               name, status(), bus.bit_count, {4'b0011, ef}, used);
    end
    bus.bit_valid = 1'b1;
    bus.a_bit     = 1'($urandom);
    bus.b_bit     = 1'($urandom);
    @(negedge clk);
    bus.bit_valid = 1'b0;
    checks++;
    if (status() !== {4'b0001, ef} || bus.bit_count !== CW'(used)) begin
      failures++;
      $display("FAIL %s_hold status=%b count=%0d expected status=%b count=%0d",
               name, status(), bus.bit_count, {4'b0001, ef}, used);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (status() !== 7'b0000000 || bus.bit_count !== CW'(0)) begin
      failures++;
      $display("FAIL reset status=%b count=%0d expected status=0000000 count=0",
               status(), bus.bit_count);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (status() !== 7'b0000000 || bus.bit_count !== CW'(0)) begin
      failures++;
      $display("FAIL idle status=%b count=%0d expected status=0000000 count=0",
               status(), bus.bit_count);
    end
  endtask

  task automatic test_directed();
    do_compare(4'b1010, 4'b1001, 0, 1'b0, "a_gt");
    do_compare(4'b0111, 4'b1000, 0, 1'b0, "b_gt_msb");
    do_compare(4'b1100, 4'b0100, 0, 1'b0, "msb_decides");
  endtask

  task automatic test_stall();
    do_compare(4'b0110, 4'b0110, 2, 1'b0, "eq_stall");
  endtask

  task automatic test_abort();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.bit_valid = 1'b1;
      bus.a_bit     = 1'b0;
      bus.b_bit     = 1'b0;
      @(negedge clk);
      bus.bit_valid = 1'b0;
    end
    checks++;
    if (bus.bit_count !== CW'(2) || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL abort_pre count=%0d done=%b expected count=2 done=0",
               bus.bit_count, bus.done);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (status() !== 7'b0000000 || bus.bit_count !== CW'(0)) begin
      failures++;
      $display("FAIL abort_reset status=%b count=%0d expected status=0000000 count=0",
               status(), bus.bit_count);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done done=%b expected 0", bus.done);
    end
    do_compare(4'b0001, 4'b0000, 0, 1'b0, "after_abort");
  endtask

  task automatic test_start_ignored();
    do_compare(4'b0011, 4'b0101, 0, 1'b1, "start_in_compare");
    do_compare(4'b1001, 4'b1001, 1, 1'b1, "start_in_compare_eq");
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a;
    logic [N-1:0] b;
    for (int t = 0; t < 24; t++) begin
      a = N'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : N'($urandom);
      do_compare(a, b, int'($urandom_range(0, 2)), 1'($urandom), "random");
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.a_bit     = 1'b0;
    bus.b_bit     = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_stall();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comparador_serial_izq_der.md
Name: comparador_serial_izq_der

Overview:
Sequential counterpart of the iterative A/B word comparator network. It scans the words in the opposite direction, left to right (MSB first), one bit pair per accepted transfer.
- Holds the running relation in a 2-bit state register P, equivalent to the iterative cell's prox_estado.
- Reports A>B, A<B or A==B after N bits, with a start/valid/ready/done handshake.
- Sits between a serial bit source (shift register or external interface) and downstream control logic.

Parameters:
N, 8, word width in bits (N >= 2); number of bit pairs accepted per comparison.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  pulse requesting a new comparison; honoured only in IDLE or DONE
bit_valid  input  1  a_bit/b_bit carry a valid MSB-first bit pair this cycle
a_bit  input  1  current bit of word A
b_bit  input  1  current bit of word B
bit_ready  output  1  block accepts a bit pair this cycle (high only in COMPARE)
busy  output  1  comparison in progress (COMPARE)
done  output  1  one-cycle pulse when the result becomes final
a_mayor  output  1  A > B (valid while result_valid)
b_mayor  output  1  B > A (valid while result_valid)
iguales  output  1  A == B (valid while result_valid)
result_valid  output  1  result flags hold a completed comparison
bit_count  output  $clog2(N+1)  number of bit pairs accepted so far

Behaviour:
- Reset: FSM=IDLE, P=IGUAL. All outputs are 0: bit_ready, busy, done, a_mayor, b_mayor, iguales, result_valid and bit_count. Reset mid-comparison aborts it with no done pulse.
- FSM states are IDLE, COMPARE and DONE.
- IDLE, start=1: go to COMPARE next cycle.
  - P <= IGUAL, bit_count <= 0.
  - result_valid <= 0; a_mayor, b_mayor and iguales are cleared.
- COMPARE: bit_ready=busy=1. A transfer occurs when bit_valid && bit_ready.
  - On a transfer, bit_count increments.
  - P is updated only while P==IGUAL: a_bit>b_bit gives A_MAYOR, a_bit<b_bit gives B_MAYOR, equal bits keep IGUAL.
  - Once P!=IGUAL, P is sticky (MSB dominance).
  - bit_valid=0 stalls; state and count are held.
- Completion: on the transfer that makes bit_count reach N, go to DONE.
  - The flags are registered from the final P, including that last bit, in the same edge.
  - done=1 for exactly the first cycle in DONE; result_valid=1.
  - Latency from the last accepted bit to done is 1 cycle.
- DONE: flags and result_valid held indefinitely. start=1 starts a new comparison with the same effect as from IDLE; result_valid drops the next cycle.
- start while in COMPARE is ignored; the comparison continues.
- Exactly one of a_mayor/b_mayor/iguales is high whenever result_valid=1; all are 0 otherwise.
- bit_count saturates at N and never wraps.
- bit_valid is ignored outside COMPARE.

Optional Feature:
Macro COMPARADOR_EARLY_DONE_EN.
- Defined: on the transfer where P leaves IGUAL, go directly to DONE with the corresponding flag.
  - Remaining bits are not accepted (bit_ready=0); the source must flush or restart.
  - bit_count reports the bits actually consumed.
  - Words equal in all N bits still end after N bits.
- Undefined: always consume exactly N bit pairs, as described above.

Decomposition:
Shared include file comparador_defs.vh holds:
- P encodings: IGUAL=2'b00, A_MAYOR=2'b01, B_MAYOR=2'b10.
- FSM encodings: IDLE=2'b00, COMPARE=2'b01, DONE=2'b10.

One sub-module is natural: celda_izq_der, a combinational next-P function (P, a_bit, b_bit -> P_next). The top block instantiates it once and registers its output; it is reusable in a parallel left-to-right iterative network.

Test Plan:
- N=4, reset then start, stream A=1010, B=1001 MSB first with bit_valid=1 → done pulse 1 cycle after the 4th bit; a_mayor=1, b_mayor=0, iguales=0, bit_count=4.
- A=0111, B=1000 → b_mayor=1, decided on the MSB and unchanged by the LSBs; done after 4 bits (without the macro).
- A=B=0110 with bit_valid gaps of 2 cycles between bits → iguales=1, bit_count holds during stalls, done only after the 4th transfer.
- Assert reset after 2 bits, then start and send A=0001, B=0000 → no done from the aborted run; the new run ends with a_mayor=1.
- start pulsed during COMPARE → ignored; result unchanged. From DONE, start → result_valid=0 next cycle and flags cleared.
- With COMPARADOR_EARLY_DONE_EN, A=1100, B=0100 → done 1 cycle after the 1st bit, a_mayor=1, bit_count=1, bit_ready=0 afterwards.
